serial_fsm_arbiter: RTL and testbench
=====================================

Name: serial_fsm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bit-serial Moore FSM datapath among NUM_REQ requesters. Datapath interface: 1-bit input x, 1-bit output y, active-low reset.
- Per granted request, the block:
  - clears the FSM;
  - shifts a WORD_W-bit word into it one bit per clock;
  - collects the FSM's y response bit by bit;
  - returns the collected word to the winner with a one-cycle done pulse.
- Sits between requester logic and the shared serial FSM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per serial word (2..16).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- data_in  input  NUM_REQ*WORD_W  requester words; slice i = data_in[i*WORD_W +: WORD_W].
- grant  output  NUM_REQ  one-hot grant, held for the whole operation.
- owner  output  3  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- fsm_rst_n  output  1  active-low reset to the shared FSM.
- fsm_x  output  1  serial bit into the FSM.
- fsm_y  input  1  FSM Moore output.
- result  output  WORD_W  collected response word; held until the next done.
- done  output  1  one-cycle pulse; result valid in the same cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, port names clock and reset.
- All outputs are registered.
- Reset values:
  - grant=0, owner=0, busy=0, fsm_x=0, result=0, done=0.
  - fsm_rst_n=0 while reset is high.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - fsm_rst_n=1.
  - If any req bit is set, pick the first requester in order last+1, last+2, … (wrapping modulo NUM_REQ).
  - Register grant and owner, latch its data_in slice into the shift register, set last=winner, go to CLEAR.
  - No req: stay in IDLE.
- CLEAR: fsm_rst_n=0 for exactly one cycle; bit counter k=0; go to SHIFT.
- SHIFT, WORD_W cycles:
  - Cycle k drives fsm_x = word[k] (LSB first).
  - For k≥1, fsm_y is sampled at the end of cycle k into result bit k-1.
  - After k=WORD_W-1, go to DRAIN.
- DRAIN, one cycle: fsm_x=0; fsm_y sampled into result bit WORD_W-1; go to DONE.
- DONE:
  - done=1 and result valid.
  - grant cleared at the end of the cycle; go to IDLE.
- Latency: req sampled in IDLE at cycle t → grant visible at t+1 → done at t+WORD_W+3.
- Throughput: one IDLE cycle between operations; back-to-back requests alternate per RR.
- Requester deasserting req mid-operation: ignored; the operation completes and done still pulses.
- data_in changes after grant: ignored (word latched at grant).
- Simultaneous requests: RR order only; a requester is never granted twice in a row while another requester is asserting req.
- Synchronous reset mid-operation:
  - Next cycle is IDLE with all reset values and fsm_rst_n=0 during reset.
  - No done pulse; result cleared to 0; last reset to NUM_REQ-1.
- owner: values ≥ NUM_REQ never produced.

Optional Feature:
- MSB_FIRST_EN defined: SHIFT drives word[WORD_W-1-k]; fsm_y samples fill result from MSB down (first sample → result[WORD_W-1]).
- MSB_FIRST_EN undefined: LSB-first ordering as above.
- Latency and handshake are identical in both builds.

Test Plan:
- Bench models the FSM as a D flop: y <= x, cleared when fsm_rst_n=0.
- Single request: req=0001, slice0=8'hA5 → grant=0001 at t+1, fsm_rst_n low one cycle at t+1, fsm_x=1,0,1,0,0,1,0,1, done at t+11 with result=8'hA5, owner=0.
- Round-robin: req=1111 held, slices 11/22/33/44 → grants in order 0001, 0010, 0100, 1000, 0001; results match each slice; one IDLE cycle between each done and the next grant.
- Drop mid-op: req=0100, deassert on the 3rd SHIFT cycle → operation still completes, done=1, result = slice2, grant cleared after DONE.
- Reset mid-op: assert reset on the 4th SHIFT cycle → next cycle all outputs at reset values, no done; then req=0010 → requester 1 granted normally (pointer restarted at 0 priority order).
- MSB_FIRST_EN build: slice0=8'h01 → fsm_x sequence 0,0,0,0,0,0,0,1; result=8'h01.

Source files
------------

// File: rtl/serial_fsm_arbiter.sv
// Round-robin arbiter that time-shares one bit-serial Moore FSM among NUM_REQ requesters.
// Build option MSB_FIRST_EN: shift words out and collect responses MSB first instead of LSB first.
module serial_fsm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic                      fsm_rst_n,
  output logic                      fsm_x,
  input  logic                      fsm_y,
  output logic [WORD_W-1:0]         result,
  output logic                      done
);

  localparam int KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [2:0]        last_q;
  logic [WORD_W-1:0] sh_q;
  logic [WORD_W-1:0] col_q;
  logic [KW-1:0]     k_q;

  logic              win_vld_d;
  logic [2:0]        win_idx_d;
  logic [WORD_W-1:0] win_word_d;

  function automatic logic first_bit(input logic [WORD_W-1:0] w);
`ifdef MSB_FIRST_EN
    return w[WORD_W-1];
`else
    return w[0];
`endif
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
`ifdef MSB_FIRST_EN
    return {w[WORD_W-2:0], 1'b0};
`else
    return {1'b0, w[WORD_W-1:1]};
`endif
  endfunction

  // After WORD_W inserts the first sample lands at bit 0 (LSB build) or bit WORD_W-1 (MSB build).
  function automatic logic [WORD_W-1:0] insert(input logic [WORD_W-1:0] c, input logic b);
`ifdef MSB_FIRST_EN
    return {c[WORD_W-2:0], b};
`else
    return {b, c[WORD_W-1:1]};
`endif
  endfunction

  // Search starts one past the last winner so nobody is granted twice while others wait.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = 3'd0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      if (!win_vld_d && req[(int'(last_q) + j) % NUM_REQ]) begin
        win_vld_d = 1'b1;
        win_idx_d = 3'((int'(last_q) + j) % NUM_REQ);
      end
    end
    win_word_d = data_in[int'(win_idx_d)*WORD_W +: WORD_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant     <= '0;
      owner     <= 3'd0;
      busy      <= 1'b0;
      fsm_rst_n <= 1'b0;
      fsm_x     <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      last_q    <= 3'(NUM_REQ-1);
      sh_q      <= '0;
      col_q     <= '0;
      k_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          fsm_rst_n <= 1'b1;
          done      <= 1'b0;
          if (win_vld_d) begin
            grant     <= NUM_REQ'(1) << win_idx_d;
            owner     <= win_idx_d;
            last_q    <= win_idx_d;
            sh_q      <= win_word_d;
            busy      <= 1'b1;
            fsm_rst_n <= 1'b0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          fsm_rst_n <= 1'b1;
          k_q       <= '0;
          fsm_x     <= first_bit(sh_q);
          sh_q      <= advance(sh_q);
          state_q   <= SHIFT;
        end
        SHIFT: begin
          // The FSM output lags its input by one cycle, so nothing useful arrives during k=0.
          if (k_q != '0) col_q <= insert(col_q, fsm_y);
          if (k_q == KW'(WORD_W-1)) begin
            fsm_x   <= 1'b0;
            state_q <= DRAIN;
          end else begin
            fsm_x <= first_bit(sh_q);
            sh_q  <= advance(sh_q);
            k_q   <= k_q + KW'(1);
          end
        end
        DRAIN: begin
          result  <= insert(col_q, fsm_y);
          done    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fsm_arbiter.sv
// Bench for serial_fsm_arbiter: cycle-level reference model plus directed scenarios with literal expectations.
module tb_serial_fsm_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WORD_W  = 8;
  localparam int OPLEN   = WORD_W + 3;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WORD_W-1:0] data_in;
  logic [NUM_REQ-1:0]        grant;
  logic [2:0]                owner;
  logic                      busy, fsm_rst_n, fsm_x, done;
  logic                      fsm_y = 1'b0;
  logic [WORD_W-1:0]         result;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  serial_fsm_arbiter #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .owner(owner), .busy(busy), .fsm_rst_n(fsm_rst_n), .fsm_x(fsm_x), .fsm_y(fsm_y),
    .result(result), .done(done)
  );

  always #5 clock = ~clock;

  // Shared serial FSM stand-in: a D flop cleared while fsm_rst_n is low.
  always @(posedge clock) fsm_y <= fsm_rst_n ? fsm_x : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
    for (int j = 1; j <= NUM_REQ; j++)
      if (r[(last + j) % NUM_REQ]) return (last + j) % NUM_REQ;
    return -1;
  endfunction

  // Reference model: an operation occupies cycles n=1..OPLEN after the winning IDLE cycle.
  bit                m_active, m_rst_prev;
  int                m_n, m_win, m_last, m_pick;
  logic [WORD_W-1:0] m_word, m_result;

  always_comb m_pick = rr_pick(m_last, req);

  always @(posedge clock) begin
    if (reset) begin
      m_active   <= 0;
      m_n        <= 0;
      m_win      <= 0;
      m_last     <= NUM_REQ - 1;
      m_result   <= '0;
      m_rst_prev <= 1;
    end else begin
      m_rst_prev <= 0;
      if (m_active) begin
        if (m_n == OPLEN) m_active <= 0;
        else m_n <= m_n + 1;
        if (m_n + 1 == OPLEN) m_result <= m_word;
      end else if (m_pick >= 0) begin
        m_active <= 1;
        m_n      <= 1;
        m_win    <= m_pick;
        m_last   <= m_pick;
        m_word   <= data_in[m_pick*WORD_W +: WORD_W];
      end
    end
  end

  function automatic logic exp_x();
    int idx;
    if (!m_active || m_n < 2 || m_n > WORD_W + 1) return 1'b0;
`ifdef MSB_FIRST_EN
    idx = WORD_W - 1 - (m_n - 2);
`else
    idx = m_n - 2;
`endif
    return m_word[idx];
  endfunction

  always @(negedge clock) begin
    if (started) begin
      chk("grant",     32'(grant),     m_active ? 32'(1) << m_win : 32'd0);
      chk("owner",     32'(owner),     32'(m_win));
      chk("busy",      32'(busy),      32'(m_active));
      chk("fsm_rst_n", 32'(fsm_rst_n), (m_rst_prev || (m_active && m_n == 1)) ? 32'd0 : 32'd1);
      chk("fsm_x",     32'(fsm_x),     32'(exp_x()));
      chk("done",      32'(done),      32'(m_active && m_n == OPLEN));
      chk("result",    32'(result),    32'(m_result));
    end
  end

  logic [3:0]        eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0]        er [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [WORD_W-1:0] seq, w0, seq_exp;

  initial begin
    reset = 1'b1; req = '0; data_in = '0;
    @(posedge clock); #1 started = 1;
    repeat (2) @(negedge clock);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_fsm_rst_n", 32'(fsm_rst_n), 0);

`ifdef MSB_FIRST_EN
    w0 = 8'h01; seq_exp = 8'h80;
`else
    w0 = 8'hA5; seq_exp = 8'hA5;
`endif
    // Single request from requester 0.
    reset = 1'b0; req = 4'b0001; data_in[7:0] = w0;
    @(negedge clock);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_clear", 32'(fsm_rst_n), 0);
    req = '0;
    for (int i = 0; i < WORD_W; i++) begin
      @(negedge clock);
      seq[i] = fsm_x;
    end
    chk("t1_xseq", 32'(seq), 32'(seq_exp));
    repeat (2) @(negedge clock);
    chk("t1_done", 32'(done), 1);
    chk("t1_result", 32'(result), 32'(w0));
    chk("t1_owner", 32'(owner), 0);

    // Round robin with all four requesting continuously.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0; req = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int m = 0; m < 5; m++) begin
      @(negedge clock);
      chk("rr_grant", 32'(grant), 32'(eg[m]));
      if (m == 4) req = '0;
      repeat (10) @(negedge clock);
      chk("rr_done", 32'(done), 1);
      chk("rr_result", 32'(result), 32'(er[m]));
      @(negedge clock);
      chk("rr_idle", 32'({busy, grant}), 0);
    end

    // Requester 2 drops req on the third SHIFT cycle.
    req = 4'b0100;
    @(negedge clock);
    chk("drop_grant", 32'(grant), 32'h4);
    repeat (3) @(negedge clock);
    req = '0;
    repeat (7) @(negedge clock);
    chk("drop_done", 32'(done), 1);
    chk("drop_result", 32'(result), 32'h33);
    @(negedge clock);
    chk("drop_grant_clr", 32'(grant), 0);
    chk("drop_owner", 32'(owner), 2);

    // Reset asserted on the fourth SHIFT cycle.
    req = 4'b0001;
    @(negedge clock);
    req = '0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_outs", 32'({grant, owner, busy, fsm_x, done}), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_fsm_rst_n", 32'(fsm_rst_n), 0);
    reset = 1'b0; req = 4'b0010;
    @(negedge clock);
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_owner", 32'(owner), 1);
    req = '0;
    repeat (10) @(negedge clock);
    chk("post_rst_done", 32'(done), 1);
    chk("post_rst_result", 32'(result), 32'h22);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
